// File: rtl/line_pkg.sv
// ============================================================================
// Module : line_pkg
// Brief  : Shared constants for the line-draw sequencer and its setup logic.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_pkg;

    localparam int LINE_WIDTH = 13;

    localparam int YSTEP_POS = 1;
    localparam int YSTEP_NEG = -1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SWAP  = 3'd1;
    localparam logic [2:0] ST_DELTA = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/line_setup_swap.sv
// ============================================================================
// Module : line_setup_swap
// Brief  : Combinational steep test, endpoint swaps and delta/ystep derivation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_setup_swap
    import line_pkg::*;
#(
    parameter int WIDTH = LINE_WIDTH
) (
    input  logic [WIDTH-1:0] x0_i,
    input  logic [WIDTH-1:0] y0_i,
    input  logic [WIDTH-1:0] x1_i,
    input  logic [WIDTH-1:0] y1_i,
    output logic             steep_o,
    output logic [WIDTH-1:0] sx0_o,
    output logic [WIDTH-1:0] sy0_o,
    output logic [WIDTH-1:0] sx1_o,
    output logic [WIDTH-1:0] dx_o,
    output logic [WIDTH-1:0] dy_o,
    output logic             yneg_o
);

    function automatic logic signed [WIDTH-1:0] abs_s(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    logic signed [WIDTH-1:0] w_x0, w_y0, w_x1, w_y1;
    logic signed [WIDTH-1:0] w_ax0, w_ay0, w_ax1, w_ay1;
    logic signed [WIDTH-1:0] w_bx0, w_by0, w_bx1, w_by1;
    logic                    w_steep, w_flip;

    assign w_x0 = x0_i;
    assign w_y0 = y0_i;
    assign w_x1 = x1_i;
    assign w_y1 = y1_i;

    always_comb begin
        // A tie between |dx| and |dy| stays non-steep.
        w_steep = abs_s(w_y1 - w_y0) > abs_s(w_x1 - w_x0);
        w_ax0   = w_steep ? w_y0 : w_x0;
        w_ay0   = w_steep ? w_x0 : w_y0;
        w_ax1   = w_steep ? w_y1 : w_x1;
        w_ay1   = w_steep ? w_x1 : w_y1;
        w_flip  = w_ax0 > w_ax1;
        w_bx0   = w_flip ? w_ax1 : w_ax0;
        w_by0   = w_flip ? w_ay1 : w_ay0;
        w_bx1   = w_flip ? w_ax0 : w_ax1;
        w_by1   = w_flip ? w_ay0 : w_ay1;
    end

    assign steep_o = w_steep;
    assign sx0_o   = w_bx0;
    assign sy0_o   = w_by0;
    assign sx1_o   = w_bx1;
    assign dx_o    = w_bx1 - w_bx0;
    assign dy_o    = abs_s(w_by1 - w_by0);
    assign yneg_o  = !(w_by0 < w_by1);

endmodule

`default_nettype wire

// File: rtl/line_draw_ctrl.sv
// ============================================================================
// Module : line_draw_ctrl
// Brief  : Line request sequencer driving a Bresenham error unit and pixel writer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_draw_ctrl
    import line_pkg::*;
#(
    parameter int WIDTH = LINE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] x0_in,
    input  logic [WIDTH-1:0] y0_in,
    input  logic [WIDTH-1:0] x1_in,
    input  logic [WIDTH-1:0] y1_in,
    input  logic             abort,
    output logic             err_rst,
    output logic             err_start,
    output logic             err_last_count,
    output logic [WIDTH-1:0] err_deltax,
    output logic [WIDTH-1:0] err_deltay,
    output logic [WIDTH-1:0] err_ystep,
    output logic [WIDTH-1:0] err_x0,
    output logic [WIDTH-1:0] err_y0,
    output logic [WIDTH-1:0] err_xcount,
    input  logic [WIDTH-1:0] err_y_coord,
    input  logic             err_en_counter,
    output logic             pix_valid,
    output logic [WIDTH-1:0] pix_x,
    output logic [WIDTH-1:0] pix_y,
    output logic             busy,
    output logic             done
);

    logic [2:0]       state_q, state_d;
    logic             rst_pulse_q;
    logic [WIDTH-1:0] x0_q, y0_q, x1_q, y1_q;
    logic             steep_q;
    logic [WIDTH-1:0] sx0_q, sy0_q, x_end_q;
    logic [WIDTH-1:0] dx_q, dy_q, ystep_q;
    logic [WIDTH-1:0] xcount_q, xcount_d;

    logic             w_steep, w_yneg;
    logic [WIDTH-1:0] w_sx0, w_sy0, w_sx1, w_dx, w_dy;
    logic             w_last, w_pix;

    line_setup_swap #(
        .WIDTH (WIDTH)
    ) u_setup (
        .x0_i    (x0_q),
        .y0_i    (y0_q),
        .x1_i    (x1_q),
        .y1_i    (y1_q),
        .steep_o (w_steep),
        .sx0_o   (w_sx0),
        .sy0_o   (w_sy0),
        .sx1_o   (w_sx1),
        .dx_o    (w_dx),
        .dy_o    (w_dy),
        .yneg_o  (w_yneg)
    );

    assign w_last = (xcount_q == x_end_q);
    assign w_pix  = (state_q == ST_RUN) && err_en_counter;

    always_comb begin
        state_d  = state_q;
        xcount_d = xcount_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = ST_SWAP;
            ST_SWAP:  state_d = abort ? ST_FIN : ST_DELTA;
            ST_DELTA: begin
                state_d  = abort ? ST_FIN : ST_START;
                xcount_d = sx0_q;
            end
            ST_START: state_d = abort ? ST_FIN : ST_RUN;
            ST_RUN: begin
                if (err_en_counter) begin
                    if (w_last) state_d = ST_FIN;
                    else        xcount_d = xcount_q + WIDTH'(1);
                end
                // The pixel of this cycle still goes out; abort only blocks later ones.
                if (abort) state_d = ST_FIN;
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rst_pulse_q <= 1'b1;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            steep_q     <= 1'b0;
            sx0_q       <= '0;
            sy0_q       <= '0;
            x_end_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            ystep_q     <= '0;
            xcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            xcount_q    <= xcount_d;
            rst_pulse_q <= 1'b0;
            if (state_q == ST_IDLE && req_valid) begin
                x0_q <= x0_in;
                y0_q <= y0_in;
                x1_q <= x1_in;
                y1_q <= y1_in;
            end
            if (state_q == ST_SWAP) begin
                steep_q <= w_steep;
                sx0_q   <= w_sx0;
                sy0_q   <= w_sy0;
                x_end_q <= w_sx1;
            end
            if (state_q == ST_DELTA) begin
                dx_q    <= w_dx;
                dy_q    <= w_dy;
                ystep_q <= w_yneg ? WIDTH'(YSTEP_NEG) : WIDTH'(YSTEP_POS);
            end
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FIN);
    assign err_rst        = rst_pulse_q || (state_q == ST_DELTA);
    assign err_start      = (state_q == ST_START);
    assign err_last_count = ((state_q == ST_START) || (state_q == ST_RUN)) && w_last;
    assign err_deltax     = dx_q;
    assign err_deltay     = dy_q;
    assign err_ystep      = ystep_q;
    assign err_x0         = sx0_q;
    assign err_y0         = sy0_q;
    assign err_xcount     = xcount_q;

    // Steep lines were drawn with x/y exchanged; swap back to screen space.
    assign pix_valid = w_pix;
    assign pix_x     = w_pix ? (steep_q ? err_y_coord : xcount_q) : '0;
    assign pix_y     = w_pix ? (steep_q ? xcount_q : err_y_coord) : '0;

endmodule

`default_nettype wire
